// File: rtl/i2c_slave_responder_if.sv
// i2c_slave_responder_if: bus pins and byte-stream handshakes of the I2C slave
// responder. The slave modport is used by the responder, the master modport by
// whatever drives the bus pins and the byte streams.
interface i2c_slave_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       sda_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       start_o;
    logic       stop_o;
    logic       busy_o;

    modport slave (
        input  scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        output scl_o, sda_o, rx_data_o, rx_valid_o, tx_ready_o,
               start_o, stop_o, busy_o
    );

    modport master (
        output scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  scl_o, sda_o, rx_data_o, rx_valid_o, tx_ready_o,
               start_o, stop_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C slave answering one 7-bit address. Written bytes are
// delivered on the rx stream, read bytes are taken from the tx stream.
// Optional macro I2C_SLAVE_CLK_STRETCH_EN: when defined, a read with no tx byte
// available holds SCL low until one arrives; otherwise 8'hFF is returned.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    i2c_slave_responder_if.slave        bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_STRETCH  = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       ack_q, ack_d;

    logic       scl_q, scl_d, sda_q, sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic       start_q, start_d, stop_q, stop_d, busy_q, busy_d;

    logic       ack_exit_s, enter_rd_s, go_stretch_s;
    logic [7:0] load_byte_s;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;
    assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Second SCL fall of an ACK slot (for RD_ACK: fall after a master ACK).
    assign ack_exit_s = ~start_s & ~stop_s & scl_fall_s & (cnt_q == 4'd1);
    assign enter_rd_s = ack_exit_s &
                        (((state_q == S_ADDR_ACK) & sr_q[0]) | (state_q == S_RD_ACK));
    assign load_byte_s = bus.tx_valid_i ? bus.tx_data_i : 8'hFF;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign go_stretch_s = ~bus.tx_valid_i;
`else
    assign go_stretch_s = 1'b0;
`endif

    // Pin synchronizers plus one history stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // State register with bit counter, shift register and ACK decision.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sr_q    <= 8'h00;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic; START/STOP take priority over any bit edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ack_d   = ack_q;
        if (start_s) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
        end else if (stop_s) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ADDR: begin
                    if (scl_rise_s) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            state_d = (sr_q[6:0] == SLAVE_ADDR) ? S_ADDR_ACK : S_IDLE;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end else begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR_ACK, S_WR_ACK, S_RD_ACK: begin
                    if (state_q == S_RD_ACK && scl_rise_s) begin
                        // Master ACK keeps the read going, NACK ends it.
                        if (sda_s) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall_s && state_q != S_RD_ACK && cnt_q == 4'd0) begin
                        cnt_d = 4'd1;
                    end else if (enter_rd_s) begin
                        cnt_d   = 4'd0;
                        sr_d    = load_byte_s;
                        state_d = go_stretch_s ? S_STRETCH : S_RD_DATA;
                    end else if (ack_exit_s) begin
                        cnt_d = 4'd0;
                        if (state_q == S_WR_ACK && !ack_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise_s) begin
                        sr_d  = {sr_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            ack_d   = bus.rx_ready_i;
                            state_d = S_WR_ACK;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise_s) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall_s) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d   = 4'd0;
                            state_d = S_RD_ACK;
                        end else begin
                            sr_d = {sr_q[6:0], 1'b1};
                        end
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end
                S_STRETCH: begin
                    if (bus.tx_valid_i) begin
                        sr_d    = bus.tx_data_i;
                        cnt_d   = 4'd0;
                        state_d = S_RD_DATA;
                    end else begin
                        state_d = S_STRETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Output next values: pin drives, stream strobes and bus-condition pulses.
    always_comb begin
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        if (start_s) begin
            sda_d   = 1'b1;
            start_d = 1'b1;
        end else if (stop_s) begin
            sda_d  = 1'b1;
            stop_d = 1'b1;
        end else begin
            case (state_q)
                S_ADDR_ACK, S_WR_ACK, S_RD_ACK: begin
                    if (scl_fall_s && state_q != S_RD_ACK && cnt_q == 4'd0) begin
                        sda_d = (state_q == S_WR_ACK) ? ~ack_q : 1'b0;
                    end else if (enter_rd_s) begin
                        sda_d      = go_stretch_s ? 1'b1 : load_byte_s[7];
                        tx_ready_d = ~go_stretch_s & bus.tx_valid_i;
                    end else if (ack_exit_s) begin
                        sda_d = 1'b1;
                    end else begin
                        sda_d = sda_q;
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise_s && cnt_q == 4'd7) begin
                        rx_data_d  = {sr_q[6:0], sda_s};
                        rx_valid_d = bus.rx_ready_i;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall_s) begin
                        sda_d = (cnt_q == 4'd8) ? 1'b1 : sr_q[6];
                    end else begin
                        sda_d = sda_q;
                    end
                end
                S_STRETCH: begin
                    if (bus.tx_valid_i) begin
                        sda_d      = bus.tx_data_i[7];
                        tx_ready_d = 1'b1;
                    end else begin
                        sda_d = 1'b1;
                    end
                end
                default: begin
                    sda_d = 1'b1;
                end
            endcase
        end
        if (state_d == S_IDLE) begin
            busy_d = 1'b0;
        end else if (state_q == S_ADDR && state_d == S_ADDR_ACK) begin
            busy_d = 1'b1;
        end else begin
            busy_d = busy_q;
        end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // SCL is released one cycle after the first read bit is driven.
        scl_d = ~((state_d == S_STRETCH) ||
                  ((state_q == S_STRETCH) && !start_s && !stop_s));
`else
        scl_d = 1'b1;
`endif
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.scl_o      = scl_q;
    assign bus.sda_o      = sda_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.tx_ready_o = tx_ready_q;
    assign bus.start_o    = start_q;
    assign bus.stop_o     = stop_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master against the responder; strobe
// outputs are checked by a scoreboard monitor, bus-level bits inline.
module tb_i2c_slave_responder;
    localparam int Q = 50;

    localparam int EV_START = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_RX    = 2;
    localparam int EV_TX    = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic stretch_seen = 1'b0;

    always #5 clk = ~clk;

    i2c_slave_responder_if bus();

    assign bus.scl_i = m_scl & bus.scl_o;
    assign bus.sda_i = m_sda & bus.sda_o;

    i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d/%0h required=none", k, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (k == EV_RX || k == EV_TX) check("event_data", {24'd0, d}, {24'd0, e.data});
        end
    endtask

    // Scoreboard monitor: every strobe the DUT presents is matched in order.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.start_o)    pop_cmp(EV_START, 8'h00);
            if (bus.stop_o)     pop_cmp(EV_STOP, 8'h00);
            if (bus.rx_valid_o) pop_cmp(EV_RX, bus.rx_data_o);
            if (bus.tx_ready_o) pop_cmp(EV_TX, bus.tx_data_i);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_scl_high();
        int n = 0;
        while (bus.scl_i !== 1'b1 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (bus.scl_i !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_release actual=%0b required=1", bus.scl_i);
        end
    endtask

    task automatic send_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; wait_scl_high(); #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic send_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; wait_scl_high(); #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b; #Q;
        m_scl = 1'b1; wait_scl_high(); #Q;
        s = bus.sda_i; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_o"},      {31'd0, bus.sda_o},      32'd1);
        check({tag, "_scl_o"},      {31'd0, bus.scl_o},      32'd1);
        check({tag, "_busy_o"},     {31'd0, bus.busy_o},     32'd0);
        check({tag, "_rx_data_o"},  {24'd0, bus.rx_data_o},  32'd0);
        check({tag, "_rx_valid_o"}, {31'd0, bus.rx_valid_o}, 32'd0);
        check({tag, "_tx_ready_o"}, {31'd0, bus.tx_ready_o}, 32'd0);
        check({tag, "_start_o"},    {31'd0, bus.start_o},    32'd0);
        check({tag, "_stop_o"},     {31'd0, bus.stop_o},     32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        bus.rx_ready_i = 1'b1;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Write 0x78 to address 0x22.
        push(EV_START, 8'h00); push(EV_RX, 8'h78); push(EV_STOP, 8'h00);
        send_start();
        write_byte(8'h44, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy", {31'd0, bus.busy_o}, 32'd1);
        write_byte(8'h78, ack); check("wr_data_ack", {31'd0, ack}, 32'd0);
        send_stop();
        repeat (10) @(posedge clk);
        check("wr_busy_after_stop", {31'd0, bus.busy_o}, 32'd0);
        check("wr_rx_data", {24'd0, bus.rx_data_o}, 32'h78);

        // Foreign address is ignored.
        push(EV_START, 8'h00); push(EV_STOP, 8'h00);
        send_start();
        write_byte(8'h46, ack); check("bad_addr_nak", {31'd0, ack}, 32'd1);
        check("bad_addr_busy", {31'd0, bus.busy_o}, 32'd0);
        send_stop();

        // Read 0xA5, master NACK.
        bus.tx_data_i = 8'hA5; bus.tx_valid_i = 1'b1;
        push(EV_START, 8'h00); push(EV_TX, 8'hA5); push(EV_STOP, 8'h00);
        send_start();
        write_byte(8'h45, ack); check("rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, d);
        check("rd_data", {24'd0, d}, 32'hA5);
        bus.tx_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        check("rd_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        send_stop();

        // Sink not ready: address ACK, data NACK.
        bus.rx_ready_i = 1'b0;
        push(EV_START, 8'h00); push(EV_STOP, 8'h00);
        send_start();
        write_byte(8'h44, ack); check("nr_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h12, ack); check("nr_data_nak", {31'd0, ack}, 32'd1);
        send_stop();
        bus.rx_ready_i = 1'b1;

        // Write address, repeated START, read with no tx byte ready.
        push(EV_START, 8'h00); push(EV_START, 8'h00);
        send_start();
        write_byte(8'h44, ack); check("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
        send_start();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        push(EV_TX, 8'h3C); push(EV_STOP, 8'h00);
        fork
            begin
                int n = 0;
                while (bus.scl_o !== 1'b0 && n < 2000) begin
                    @(posedge clk);
                    n++;
                end
                if (bus.scl_o === 1'b0) begin
                    stretch_seen = 1'b1;
                    repeat (30) @(posedge clk);
                    bus.tx_data_i  = 8'h3C;
                    bus.tx_valid_i = 1'b1;
                    n = 0;
                    while (bus.tx_ready_o !== 1'b1 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    @(posedge clk);
                    bus.tx_valid_i = 1'b0;
                end
            end
        join_none
        write_byte(8'h45, ack); check("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, d);
        check("rs_rd_data", {24'd0, d}, 32'h3C);
        check("rs_stretch_seen", {31'd0, stretch_seen}, 32'd1);
`else
        push(EV_STOP, 8'h00);
        write_byte(8'h45, ack); check("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, d);
        check("rs_rd_data", {24'd0, d}, 32'hFF);
`endif
        send_stop();

        // Reset mid data byte, then a normal write.
        push(EV_START, 8'h00);
        send_start();
        write_byte(8'h44, ack); check("mr_addr_ack", {31'd0, ack}, 32'd0);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        push(EV_START, 8'h00); push(EV_RX, 8'h5A); push(EV_STOP, 8'h00);
        send_start();
        write_byte(8'h44, ack); check("post_reset_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); check("post_reset_data_ack", {31'd0, ack}, 32'd0);
        send_stop();

        repeat (20) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C slave that sits directly downstream of the IICMB multi-bus controller, on its SCL/SDA bus 0.
- Answers the controller's bus transactions: decodes START/STOP, matches a 7-bit address, ACKs/NACKs, delivers written bytes on a byte stream and serves read bytes from a byte stream.
- Replaces the passive pull-up bus in the bench so write/read sequences through the controller complete with real ACKs.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit address answered; write address byte 0x44, read address byte 0x45.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i (legal values 2..3).

Ports:
- clk_i  in  1  system clock; at least 8x SCL frequency.
- rst_i  in  1  asynchronous, active-low reset.
- scl_i  in  1  I2C clock from bus (wired-AND).
- sda_i  in  1  I2C data from bus (wired-AND).
- scl_o  out 1  SCL drive; 0 = pull low, 1 = release.
- sda_o  out 1  SDA drive; 0 = pull low, 1 = release.
- rx_data_o  out 8  byte written by master.
- rx_valid_o out 1  one-cycle strobe qualifying rx_data_o.
- rx_ready_i in  1  sink can accept; sampled at 8th data bit.
- tx_data_i  in  8  byte to return on read.
- tx_valid_i in  1  tx_data_i valid.
- tx_ready_o out 1  one-cycle strobe; tx_data_i consumed this cycle.
- start_o  out 1  one-cycle pulse on START or repeated START.
- stop_o   out 1  one-cycle pulse on STOP.
- busy_o   out 1  high from address match until STOP or return to IDLE.

Behaviour:
- Reset (rst_i low, async) forces:
  - state IDLE
  - scl_o=1, sda_o=1
  - rx_data_o=8'h00; rx_valid_o, tx_ready_o, start_o, stop_o, busy_o = 0
  - synchronizers preset to 1.
- Sampling: scl_i/sda_i pass through SYNC_STAGES flops, then one history flop. Edges are detected on synchronized values only.
- START: sync SDA falls while sync SCL = 1. STOP: sync SDA rises while sync SCL = 1.
- START or STOP is honoured in every state, including mid-byte and mid-ACK. It overrides any bit edge in the same cycle.
  - START: go to ADDR, clear bit counter, release sda_o, pulse start_o.
  - STOP: go to IDLE, release sda_o/scl_o, pulse stop_o, clear busy_o.
- Data is sampled on SCL rising edge, MSB first. sda_o changes only in the cycle after a detected SCL falling edge.
- States and transitions:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits.
    - On the 8th rise: if bits[7:1] == SLAVE_ADDR, go to ADDR_ACK and set busy_o.
    - Otherwise go to IDLE (ignore bus until next START).
  - ADDR_ACK: drive sda_o=0 from the 8th SCL fall to the 9th SCL fall.
    - Then go to WR_DATA if R/W=0.
    - If R/W=1, go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rise, latch rx_data_o.
    - If rx_ready_i=1: pulse rx_valid_o the same cycle and ACK (sda_o=0 during 9th clock).
    - If rx_ready_i=0: no strobe, NACK (sda_o=1).
  - WR_ACK: on the 9th fall, go to WR_DATA. After a NACK, stay released until START/STOP.
  - RD_DATA: entering (at the SCL fall ending the ACK) loads the shift register.
    - If tx_valid_i=1: load tx_data_i and pulse tx_ready_o.
    - Otherwise: load 8'hFF, no strobe.
    - Drive bit 7 immediately, then the next bit on each SCL fall.
  - RD_ACK: release SDA after the 8th fall; sample master ACK on the 9th rise.
    - ACK (0): return to RD_DATA at the 9th fall.
    - NACK (1): go to IDLE.
- Bit counter is 4 bits and wraps to 0 on each ACK state exit. A 9th data edge without START/STOP cannot occur outside ACK states.
- Latency from pin to detection: SYNC_STAGES+1 cycles.

Optional Feature:
- Macro: I2C_SLAVE_CLK_STRETCH_EN.
- Defined: on entering RD_DATA with tx_valid_i=0, hold scl_o=0 and stay in a STRETCH state until tx_valid_i=1. Then load the byte, pulse tx_ready_o, drive bit 7, and release scl_o one cycle later. STOP/START during stretch take the normal priority rules and release scl_o.
- Undefined: scl_o is tied to 1; the 8'hFF fallback applies.

Test Plan:
- Controller writes 0x44 then 0x78, then STOP, rx_ready_i=1 → ACK on the address and data 9th clocks; rx_valid_o pulses once with rx_data_o=0x78; start_o x1, stop_o x1; busy_o low after STOP.
- Address byte 0x46 → sda_o stays 1 throughout; controller reports NAK; no rx_valid_o; busy_o stays 0.
- Read 0x45, tx_data_i=0xA5 with tx_valid_i=1, master NACK → SDA bit sequence 1,0,1,0,0,1,0,1; tx_ready_o x1; state IDLE.
- Write 0x44 then 0x12 with rx_ready_i=0 → address ACK, data NACK; no rx_valid_o.
- Write 0x44, then repeated START with 0x45, tx_valid_i=0 → start_o x2; read returns 0xFF. With I2C_SLAVE_CLK_STRETCH_EN, SCL is held low until tx_valid_i rises with 0x3C, which is then returned.
- Assert rst_i low mid-byte during WR_DATA → outputs immediately at reset values, sda_o=1. After release, the next START/0x44 transaction is ACKed normally.
